axi_rd_master_arb_mux: RTL
==========================

// Module: axi_rd_master_arb_mux
// PURPOSE
//  N-master to 1-slave AXI4 read-channel mux with a built-in round-robin arbiter and outstanding-burst tracking.
//  Sits between the master ports and the interconnect's internal read path.
//  Grant is registered and held for a whole tenure: AR accepts, then every RLAST returned.
//  R data therefore always routes to the master that issued the request, with no external grant logic.
// PARAMETERS
//  NUM_M      4   number of masters (>=2)
//  DATA_WIDTH 64  R data width
//  ADDR_WIDTH 32  AR address width
//  ID_WIDTH   8   AR/R ID width
//  USER_WIDTH 8   ARUSER/RUSER width
//  MAX_OUTS   4   max ARs accepted per tenure = max outstanding bursts (>=1)
// PORTS  (s_* flattened, master k occupies slice [k*W +: W])
//  clk            in   1                  clock
//  rstn           in   1                  async active-low reset
//  s_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER
//                 in   NUM_M*field width  per-master AR payload
//  s_ARVALID      in   NUM_M              per-master AR valid
//  s_ARREADY      out  NUM_M              per-master AR ready
//  s_RID/RDATA/RRESP/RLAST/RUSER  out  NUM_M*field width  per-master R payload
//  s_RVALID       out  NUM_M              per-master R valid
//  s_RREADY       in   NUM_M              per-master R ready
//  m_AR*          out  field width        muxed AR payload and m_ARVALID to slave side
//  m_ARREADY      in   1                  slave-side AR ready
//  m_R*           in   field width        slave-side R payload and m_RVALID
//  m_RREADY       out  1                  muxed R ready
//  grnt           out  NUM_M              one-hot current grant (0 in IDLE)
//  busy           out  1                  state != IDLE
//  err_unexp_r    out  1                  sticky: m_RVALID seen while outs==0
// BEHAVIOUR
//  Reset values (async on rstn=0):
//   - state=IDLE, grnt=0, rr_ptr=0, outs=0, acc=0, err_unexp_r=0.
//   - All AR/R valid/ready outputs 0; payload outputs 0.
//  Counters:
//   - outs, acc: $clog2(MAX_OUTS+1) bits.
//   - ar_hs = m_ARVALID&m_ARREADY; r_last_hs = m_RVALID&m_RREADY&m_RLAST.
//   - outs += ar_hs - r_last_hs; both in one cycle = no change. acc += ar_hs; cleared on IDLE.
//  IDLE:
//   - All s_ARREADY=0, s_RVALID=0, m_ARVALID=0, m_RREADY=0.
//   - If any s_ARVALID: grnt <= first requester at or after rr_ptr (wraps NUM_M-1 -> 0); go ACTIVE.
//   - Arbitration latency 1 cycle; earliest ar_hs is the cycle after the request is seen.
//  ACTIVE:
//   - m_AR* = granted payload.
//   - m_ARVALID = s_ARVALID[g] & (acc<MAX_OUTS).
//   - s_ARREADY[g] = m_ARREADY & (acc<MAX_OUTS); other ARREADY=0.
//   - Go DRAIN when acc reaches MAX_OUTS (acc+ar_hs==MAX_OUTS), or s_ARVALID[g]==0 with outs>0.
//   - s_ARVALID[g]==0 with outs==0 and no ar_hs (illegal withdraw): go IDLE directly.
//  DRAIN:
//   - m_ARVALID=0, all s_ARREADY=0.
//   - When the next outs is 0 (incl. the final r_last_hs this cycle): go IDLE, grnt<=0, rr_ptr<=(g+1)%NUM_M.
//  R path (ACTIVE/DRAIN):
//   - s_R*[g] = m_R*; s_RVALID[g] = m_RVALID; m_RREADY = s_RREADY[g].
//   - Non-granted s_RVALID=0, payload 0.
//   - RUSER passed through, not tied off.
//  err_unexp_r set whenever m_RVALID & outs==0, in any state; cleared only by reset.
//  ARVALID never drops before ARREADY on the slave side: the AR gate only closes through the acc limit on the cycle after ar_hs.
//  Reset mid-burst: all state cleared immediately, in-flight beats abandoned, outputs return to reset values.
//  All outputs are combinational from registered state/grnt plus the passed-through input.
// TESTING
//  1. NUM_M=4: s_ARVALID=4'b1111 held, each issues ARLEN=3 -> tenures granted in order 0,1,2,3,0; each sees 4 R beats.
//  2. Master 2: 4 back-to-back ARs, MAX_OUTS=4, slave RLAST delayed -> acc=4, DRAIN; 5th AR stalls until outs==0; grant released to 3.
//  3. Same-cycle ar_hs and r_last_hs with outs=2 -> outs stays 2; final RLAST with outs=1 -> IDLE on next edge.
//  4. m_RVALID=1 in IDLE -> err_unexp_r=1, all s_RVALID=0, m_RREADY=0; stays 1 until rstn.
//  5. rstn low mid-burst (outs=2, beat 1 of 4) -> grnt=0, outs=0, all valids 0 asynchronously; new arbitration after release.
//  6. s_RREADY[g]=0 for 3 cycles mid-burst -> m_RREADY=0, m_R* held, no beat lost; beat counts match ARLEN+1.

Source files
------------

// File: rtl/axi_rd_master_arb_mux.sv
// -----------------------------------------------------------------------------
// axi_rd_master_arb_mux
//   N-master to 1-slave AXI4 read-channel multiplexer with a built-in
//   round-robin arbiter and outstanding-burst tracking.
//   A grant is registered and held for a whole tenure: the winning master may
//   issue up to MAX_OUTS ARs, and the grant is held until every RLAST for those
//   ARs has returned. R beats therefore always route back to the master that
//   issued the request, so no external grant logic is needed.
//
// Ports (s_* are flattened; master k occupies slice [k*W +: W])
//   clk, rstn          clock, asynchronous active-low reset
//   s_AR*              per-master AR payload/valid in, s_ARREADY out
//   s_R*               per-master R payload/valid out, s_RREADY in
//   m_AR*              muxed AR payload/valid out, m_ARREADY in
//   m_R*               slave-side R payload/valid in, m_RREADY out
//   grnt               one-hot current grant (0 when idle)
//   busy               arbiter not idle
//   err_unexp_r        sticky: R valid seen with nothing outstanding
// -----------------------------------------------------------------------------
module axi_rd_master_arb_mux #(
    parameter int unsigned NUM_M      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned MAX_OUTS   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    // Master-side AR
    input  logic [NUM_M*ID_WIDTH-1:0]   s_ARID,
    input  logic [NUM_M*ADDR_WIDTH-1:0] s_ARADDR,
    input  logic [NUM_M*8-1:0]          s_ARLEN,
    input  logic [NUM_M*3-1:0]          s_ARSIZE,
    input  logic [NUM_M*2-1:0]          s_ARBURST,
    input  logic [NUM_M-1:0]            s_ARLOCK,
    input  logic [NUM_M*4-1:0]          s_ARCACHE,
    input  logic [NUM_M*3-1:0]          s_ARPROT,
    input  logic [NUM_M*4-1:0]          s_ARQOS,
    input  logic [NUM_M*4-1:0]          s_ARREGION,
    input  logic [NUM_M*USER_WIDTH-1:0] s_ARUSER,
    input  logic [NUM_M-1:0]            s_ARVALID,
    output logic [NUM_M-1:0]            s_ARREADY,
    // Master-side R
    output logic [NUM_M*ID_WIDTH-1:0]   s_RID,
    output logic [NUM_M*DATA_WIDTH-1:0] s_RDATA,
    output logic [NUM_M*2-1:0]          s_RRESP,
    output logic [NUM_M-1:0]            s_RLAST,
    output logic [NUM_M*USER_WIDTH-1:0] s_RUSER,
    output logic [NUM_M-1:0]            s_RVALID,
    input  logic [NUM_M-1:0]            s_RREADY,
    // Slave-side AR
    output logic [ID_WIDTH-1:0]         m_ARID,
    output logic [ADDR_WIDTH-1:0]       m_ARADDR,
    output logic [7:0]                  m_ARLEN,
    output logic [2:0]                  m_ARSIZE,
    output logic [1:0]                  m_ARBURST,
    output logic                        m_ARLOCK,
    output logic [3:0]                  m_ARCACHE,
    output logic [2:0]                  m_ARPROT,
    output logic [3:0]                  m_ARQOS,
    output logic [3:0]                  m_ARREGION,
    output logic [USER_WIDTH-1:0]       m_ARUSER,
    output logic                        m_ARVALID,
    input  logic                        m_ARREADY,
    // Slave-side R
    input  logic [ID_WIDTH-1:0]         m_RID,
    input  logic [DATA_WIDTH-1:0]       m_RDATA,
    input  logic [1:0]                  m_RRESP,
    input  logic                        m_RLAST,
    input  logic [USER_WIDTH-1:0]       m_RUSER,
    input  logic                        m_RVALID,
    output logic                        m_RREADY,
    // Status
    output logic [NUM_M-1:0]            grnt,
    output logic                        busy,
    output logic                        err_unexp_r
);

    localparam int GW = $clog2(NUM_M);
    localparam int CW = $clog2(MAX_OUTS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Registered state
    logic [1:0]       r_state;
    logic [NUM_M-1:0] r_grnt;
    logic [GW-1:0]    r_gidx;
    logic [GW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_outs;
    logic [CW-1:0]    r_acc;
    logic             r_err;

    // Next-state and decode
    logic [1:0]       w_state_d;
    logic [NUM_M-1:0] w_grnt_d;
    logic [GW-1:0]    w_gidx_d;
    logic [GW-1:0]    w_rr_ptr_d;
    logic [CW-1:0]    w_outs_d;
    logic [CW-1:0]    w_acc_d;
    logic             w_active;
    logic             w_conn;
    logic             w_acc_ok;
    logic             w_req_g;
    logic             w_ar_hs;
    logic             w_rlast_hs;
    logic [GW-1:0]    w_next_ptr;
    logic [GW-1:0]    w_pick;
    logic [GW-1:0]    w_pick_hi;
    logic [GW-1:0]    w_pick_lo;
    logic             w_hi_found;

    assign w_active   = (r_state == ST_ACTIVE);
    assign w_conn     = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
    assign w_acc_ok   = (r_acc < CW'(MAX_OUTS));
    assign w_req_g    = s_ARVALID[r_gidx];
    assign w_ar_hs    = m_ARVALID & m_ARREADY;
    assign w_rlast_hs = m_RVALID & m_RREADY & m_RLAST;
    assign w_next_ptr = (r_gidx == GW'(NUM_M - 1)) ? '0 : r_gidx + GW'(1);

    assign m_ARVALID = w_active & w_req_g & w_acc_ok;
    assign m_RREADY  = w_conn & s_RREADY[r_gidx];

    assign grnt        = r_grnt;
    assign busy        = (r_state != ST_IDLE);
    assign err_unexp_r = r_err;

    // Round-robin pick: lowest requester at or above rr_ptr, otherwise the
    // lowest requester overall (wrap-around). Descending scan keeps the lowest.
    always_comb begin
        w_hi_found = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int k = int'(NUM_M) - 1; k >= 0; k--) begin
            if (s_ARVALID[k]) begin
                w_pick_lo = GW'(k);
                if (k >= int'(r_rr_ptr)) begin
                    w_pick_hi  = GW'(k);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_pick = w_hi_found ? w_pick_hi : w_pick_lo;
    end

    // Outstanding-burst counter; a simultaneous accept and last beat cancel.
    // The decrement is guarded so a stray RLAST cannot wrap the counter.
    always_comb begin
        w_outs_d = r_outs;
        if (w_ar_hs && !w_rlast_hs) begin
            w_outs_d = r_outs + CW'(1);
        end else if (!w_ar_hs && w_rlast_hs && (r_outs != '0)) begin
            w_outs_d = r_outs - CW'(1);
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_grnt_d   = r_grnt;
        w_gidx_d   = r_gidx;
        w_rr_ptr_d = r_rr_ptr;
        w_acc_d    = r_acc;
        case (r_state)
            ST_IDLE: begin
                if (|s_ARVALID) begin
                    w_state_d = ST_ACTIVE;
                    w_gidx_d  = w_pick;
                    for (int k = 0; k < int'(NUM_M); k++) begin
                        w_grnt_d[k] = (k == int'(w_pick));
                    end
                end
            end
            ST_ACTIVE: begin
                w_acc_d = r_acc + CW'(w_ar_hs);
                if (w_acc_d == CW'(MAX_OUTS)) begin
                    w_state_d = ST_DRAIN;
                end else if (!w_req_g) begin
                    if (r_outs != '0) begin
                        w_state_d = ST_DRAIN;
                    end else begin
                        // Master withdrew without any AR in flight.
                        w_state_d  = ST_IDLE;
                        w_grnt_d   = '0;
                        w_rr_ptr_d = w_next_ptr;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_outs_d == '0) begin
                    w_state_d  = ST_IDLE;
                    w_grnt_d   = '0;
                    w_rr_ptr_d = w_next_ptr;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grnt_d  = '0;
            end
        endcase
        // A new tenure always starts with a clean acceptance count.
        if (w_state_d == ST_IDLE) begin
            w_acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_grnt   <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_outs   <= '0;
            r_acc    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_grnt   <= w_grnt_d;
            r_gidx   <= w_gidx_d;
            r_rr_ptr <= w_rr_ptr_d;
            r_outs   <= w_outs_d;
            r_acc    <= w_acc_d;
            if (m_RVALID && (r_outs == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // AR payload mux and per-master ready; everything reads 0 outside ACTIVE.
    always_comb begin
        m_ARID     = '0;
        m_ARADDR   = '0;
        m_ARLEN    = '0;
        m_ARSIZE   = '0;
        m_ARBURST  = '0;
        m_ARLOCK   = 1'b0;
        m_ARCACHE  = '0;
        m_ARPROT   = '0;
        m_ARQOS    = '0;
        m_ARREGION = '0;
        m_ARUSER   = '0;
        s_ARREADY  = '0;
        for (int k = 0; k < int'(NUM_M); k++) begin
            if (w_active && (k == int'(r_gidx))) begin
                m_ARID       = s_ARID[k*ID_WIDTH +: ID_WIDTH];
                m_ARADDR     = s_ARADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
                m_ARLEN      = s_ARLEN[k*8 +: 8];
                m_ARSIZE     = s_ARSIZE[k*3 +: 3];
                m_ARBURST    = s_ARBURST[k*2 +: 2];
                m_ARLOCK     = s_ARLOCK[k];
                m_ARCACHE    = s_ARCACHE[k*4 +: 4];
                m_ARPROT     = s_ARPROT[k*3 +: 3];
                m_ARQOS      = s_ARQOS[k*4 +: 4];
                m_ARREGION   = s_ARREGION[k*4 +: 4];
                m_ARUSER     = s_ARUSER[k*USER_WIDTH +: USER_WIDTH];
                s_ARREADY[k] = m_ARREADY & w_acc_ok;
            end
        end
    end

    // R demux: only the granted slice carries the slave's beat.
    always_comb begin
        s_RID    = '0;
        s_RDATA  = '0;
        s_RRESP  = '0;
        s_RLAST  = '0;
        s_RUSER  = '0;
        s_RVALID = '0;
        for (int k = 0; k < int'(NUM_M); k++) begin
            if (w_conn && (k == int'(r_gidx))) begin
                s_RID[k*ID_WIDTH +: ID_WIDTH]       = m_RID;
                s_RDATA[k*DATA_WIDTH +: DATA_WIDTH] = m_RDATA;
                s_RRESP[k*2 +: 2]                   = m_RRESP;
                s_RLAST[k]                          = m_RLAST;
                s_RUSER[k*USER_WIDTH +: USER_WIDTH] = m_RUSER;
                s_RVALID[k]                         = m_RVALID;
            end
        end
    end

endmodule
